int_controller: RTL and testbench
=================================

// Module: int_controller
// PURPOSE
//  Platform interrupt controller: arbitrates N_SRC external interrupt sources onto the single
//  irq_int_controller (MEIP) input of csr_file. Per-source gateway, enable and priority; global
//  threshold; claim/complete protocol over a valid/ready register port driven by the load/store unit.
// PARAMETERS
//  N_SRC   16  number of sources; IDs 1..N_SRC, ID 0 = "no interrupt" (1..31)
//  PRIO_W  3   priority width; priority 0 = source never interrupts
// PORTS
//  clk        in   1       clock
//  reset_n    in   1       asynchronous reset, active low
//  irq_src    in   N_SRC   raw source lines, bit i = source ID i+1, synchronous to clk
//  valid_in   in   1       register request valid
//  ready_out  out  1       request accepted when valid_in && ready_out
//  valid_out  out  1       response valid
//  ready_in   in   1       response consumed when valid_out && ready_in
//  addr       in   8       byte address, bits [1:0] ignored
//  wena       in   1       1 = write, 0 = read
//  wdata      in   32      write data
//  rdata      out  32      read data, valid with valid_out
//  irq        out  1       to csr_file irq_int_controller
// BEHAVIOUR
//  Reset: pending, in_service, enable, priorities, threshold = 0; valid_out=0, rdata=0, irq=0.
//  Register map: 0x00 PENDING (RO) | 0x04 ENABLE | 0x08 THRESHOLD [PRIO_W-1:0]
//   | 0x0C CLAIM (read) / COMPLETE (write) | 0x40+4*(id-1) PRIORITY[id]. Unmapped: read 0, write ignored.
//  Gateway (level): pending[i] sets when irq_src[i]=1 && !pending[i] && !in_service[i].
//  Arbitration: candidate = pending & enable & (prio > threshold); winner = highest priority,
//   tie -> lowest ID. irq registered: high 1 cycle after a candidate exists, low 1 cycle after none.
//  Handshake: ready_out = !valid_out || ready_in; one-cycle latency; rdata/valid_out held stable
//   while valid_out && !ready_in. All side effects occur in the accept cycle.
//  Claim read: returns winner ID (0 if none); clears pending[winner], sets in_service[winner]. ID 0 -> no change.
//  Complete write: wdata[4:0]=id; clears in_service[id] if set; id 0, id>N_SRC or not in service ignored.
//  Simultaneous: claim and new source assertion in same cycle -> both take effect; complete while
//   source still high -> pending re-sets the following cycle. Gateway and claim never conflict
//   (claim only touches pending=1 bits, gateway only sets pending=0 bits).
//  Writes to PENDING ignored; PRIORITY writes keep [PRIO_W-1:0]; ENABLE keeps [N_SRC-1:0].
//  Reset mid-transaction: response dropped, all state to reset values immediately.
// CONFIGURATION
//  INT_CTRL_EDGE_EN defined: register 0x10 EDGE_SEL (RW, reset 0); source with EDGE_SEL=1 sets
//   pending on rising edge of irq_src (one-cycle delayed sample register), edges during in_service
//   are lost; level sources unchanged. Not defined: 0x10 unmapped (reads 0), all sources level.
// STRUCTURE
//  CPU_pkg: INT_CTRL_ADDR_{PENDING,ENABLE,THRESHOLD,CLAIM,EDGE_SEL,PRIO_BASE} constants,
//   int_id_t (logic [4:0]) typedef.
//  Sub-module int_prio_arbiter: combinational winner select (candidate vector, priorities ->
//   winner ID, valid); top holds gateway, registers, handshake FSM.
// TESTING
//  Prio[3]=2, enable=0x4, thresh=0, irq_src[2]=1 -> irq=1 two cycles later; claim reads 3, irq=0 next cycle.
//  Prio[1]=5, prio[2]=5, both pending+enabled -> claim returns 1; second claim returns 2; third returns 0.
//  Thresh=5, prio[4]=5 pending -> irq stays 0; thresh=4 -> irq=1.
//  Source 3 held high, claim 3, complete 3 -> pending[2] re-set next cycle, irq re-asserts.
//  ready_in=0 for 3 cycles after claim -> rdata=3 stable, ready_out=0, no second side effect.
//  EDGE_EN: EDGE_SEL[0]=1, pulse src 1 for 1 cycle -> pending=0x1; held high after complete -> no re-pend.

Source files
------------

// File: rtl/CPU_pkg.sv
// CPU_pkg
// Purpose : shared constants and types for the platform interrupt controller.
//           Holds the register byte addresses, the source ID type and a helper
//           that maps a zero-based source index onto its PRIORITY register.
// Ports   : none (package).
// Config  : INT_CTRL_ADDR_EDGE_SEL is only decoded when INT_CTRL_EDGE_EN is defined.

package CPU_pkg;

  localparam logic [7:0] INT_CTRL_ADDR_PENDING   = 8'h00;
  localparam logic [7:0] INT_CTRL_ADDR_ENABLE    = 8'h04;
  localparam logic [7:0] INT_CTRL_ADDR_THRESHOLD = 8'h08;
  localparam logic [7:0] INT_CTRL_ADDR_CLAIM     = 8'h0C;
  localparam logic [7:0] INT_CTRL_ADDR_EDGE_SEL  = 8'h10;
  localparam logic [7:0] INT_CTRL_ADDR_PRIO_BASE = 8'h40;

  // Source IDs run 1..31; ID 0 means "no interrupt".
  typedef logic [4:0] int_id_t;

  // PRIORITY register address of zero-based source index idx (source ID idx+1).
  function automatic logic [7:0] int_ctrl_prio_addr(input int idx);
    return INT_CTRL_ADDR_PRIO_BASE + 8'(4 * idx);
  endfunction

endpackage

// File: rtl/int_prio_arbiter.sv
// int_prio_arbiter
// Purpose : combinational winner select for the interrupt controller.
//           Picks the highest-priority candidate; on equal priority the lowest
//           source ID wins.
// Ports   : candidate    in  N_SRC         sources eligible to interrupt
//           prio_flat    in  N_SRC*PRIO_W  priorities, source index i at [i*PRIO_W +: PRIO_W]
//           winner_id    out 5             winning source ID (0 when none)
//           winner_valid out 1             at least one candidate exists

module int_prio_arbiter
  import CPU_pkg::*;
#(
  parameter int N_SRC  = 16,
  parameter int PRIO_W = 3
) (
  input  logic [N_SRC-1:0]        candidate,
  input  logic [N_SRC*PRIO_W-1:0] prio_flat,
  output logic [4:0]              winner_id,
  output logic                    winner_valid
);

  logic [PRIO_W-1:0] best_prio;

  // Candidates always have priority >= 1 (they must exceed the threshold), so
  // starting from 0 with a strict compare keeps the lowest ID on ties.
  always_comb begin
    winner_id    = '0;
    best_prio    = '0;
    winner_valid = |candidate;
    for (int i = 0; i < N_SRC; i++) begin
      if (candidate[i] && (prio_flat[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio_flat[i*PRIO_W +: PRIO_W];
        winner_id = int_id_t'(i + 1);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// int_controller
// Purpose : platform interrupt controller. Gateways N_SRC external lines into
//           pending bits, arbitrates enabled pending sources above the global
//           threshold onto a single registered irq, and serves a claim/complete
//           register port with a valid/ready handshake (one-cycle latency).
// Ports   : clk        in  1      clock
//           reset_n    in  1      asynchronous reset, active low
//           irq_src    in  N_SRC  raw source lines, bit i = source ID i+1
//           valid_in   in  1      register request valid
//           ready_out  out 1      request accepted when valid_in && ready_out
//           valid_out  out 1      response valid
//           ready_in   in  1      response consumed when valid_out && ready_in
//           addr       in  8      byte address, bits [1:0] ignored
//           wena       in  1      1 = write, 0 = read
//           wdata      in  32     write data
//           rdata      out 32     read data, valid with valid_out
//           irq        out 1      interrupt request to the CSR file
// Config  : INT_CTRL_EDGE_EN adds EDGE_SEL at 0x10; selected sources pend on a
//           rising edge instead of a level. Without it 0x10 is unmapped.

module int_controller
  import CPU_pkg::*;
#(
  parameter int N_SRC  = 16,
  parameter int PRIO_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic [7:0]       addr,
  input  logic             wena,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  in_service_q, in_service_d;
  logic [N_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic              valid_out_q, valid_out_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [N_SRC-1:0]        set_req;
  logic [N_SRC-1:0]        candidate;
  logic [N_SRC*PRIO_W-1:0] prio_flat;
  logic [4:0]              winner_id;
  logic                    winner_valid;
  logic [7:0]              addr_w;
  logic [31:0]             read_data;
  logic                    accept;
  logic                    unused_bits;

  assign unused_bits = ^{addr[1:0], wdata};
  assign addr_w      = {addr[7:2], 2'b00};
  assign ready_out   = !valid_out_q || ready_in;
  assign accept      = valid_in && ready_out;
  assign valid_out   = valid_out_q;
  assign rdata       = rdata_q;
  assign irq         = irq_q;

`ifdef INT_CTRL_EDGE_EN
  logic [N_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [N_SRC-1:0] src_prev_q, src_prev_d;

  assign src_prev_d = irq_src;
  // Edge-selected sources request only on a 0->1 transition of the line.
  assign set_req = (edge_sel_q & irq_src & ~src_prev_q) | (~edge_sel_q & irq_src);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel_q <= '0;
      src_prev_q <= '0;
    end else begin
      edge_sel_q <= edge_sel_d;
      src_prev_q <= src_prev_d;
    end
  end
`else
  assign set_req = irq_src;
`endif

  // Candidate sources and flattened priorities for the arbiter.
  always_comb begin
    candidate = '0;
    prio_flat = '0;
    for (int i = 0; i < N_SRC; i++) begin
      candidate[i] = pending_q[i] && enable_q[i] && (prio_q[i] > threshold_q);
      prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
    end
  end

  int_prio_arbiter #(
    .N_SRC (N_SRC),
    .PRIO_W(PRIO_W)
  ) u_arbiter (
    .candidate   (candidate),
    .prio_flat   (prio_flat),
    .winner_id   (winner_id),
    .winner_valid(winner_valid)
  );

  // Read mux; unmapped addresses return 0.
  always_comb begin
    read_data = '0;
    if (addr_w == INT_CTRL_ADDR_PENDING) begin
      read_data[N_SRC-1:0] = pending_q;
    end else if (addr_w == INT_CTRL_ADDR_ENABLE) begin
      read_data[N_SRC-1:0] = enable_q;
    end else if (addr_w == INT_CTRL_ADDR_THRESHOLD) begin
      read_data[PRIO_W-1:0] = threshold_q;
    end else if (addr_w == INT_CTRL_ADDR_CLAIM) begin
      read_data[4:0] = winner_id;
`ifdef INT_CTRL_EDGE_EN
    end else if (addr_w == INT_CTRL_ADDR_EDGE_SEL) begin
      read_data[N_SRC-1:0] = edge_sel_q;
`endif
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (addr_w == int_ctrl_prio_addr(i)) begin
        read_data[PRIO_W-1:0] = prio_q[i];
      end
    end
  end

  // Next-state logic. The gateway only sets bits whose pending is 0, and a
  // claim only clears the winner, whose pending is 1, so they never collide.
  // A complete clears in_service this cycle; the gateway sees the old
  // in_service, so a still-high level source re-pends one cycle later.
  always_comb begin
    pending_d    = pending_q | (set_req & ~pending_q & ~in_service_q);
    in_service_d = in_service_q;
    enable_d     = enable_q;
    threshold_d  = threshold_q;
    prio_d       = prio_q;
    valid_out_d  = valid_out_q;
    rdata_d      = rdata_q;
    irq_d        = winner_valid;
`ifdef INT_CTRL_EDGE_EN
    edge_sel_d   = edge_sel_q;
`endif

    if (valid_out_q && ready_in) begin
      valid_out_d = 1'b0;
    end

    if (accept) begin
      valid_out_d = 1'b1;
      rdata_d     = '0;
      if (wena) begin
        if (addr_w == INT_CTRL_ADDR_ENABLE) begin
          enable_d = wdata[N_SRC-1:0];
        end else if (addr_w == INT_CTRL_ADDR_THRESHOLD) begin
          threshold_d = wdata[PRIO_W-1:0];
        end else if (addr_w == INT_CTRL_ADDR_CLAIM) begin
          for (int i = 0; i < N_SRC; i++) begin
            if ((wdata[4:0] == int_id_t'(i + 1)) && in_service_q[i]) begin
              in_service_d[i] = 1'b0;
            end
          end
`ifdef INT_CTRL_EDGE_EN
        end else if (addr_w == INT_CTRL_ADDR_EDGE_SEL) begin
          edge_sel_d = wdata[N_SRC-1:0];
`endif
        end
        for (int i = 0; i < N_SRC; i++) begin
          if (addr_w == int_ctrl_prio_addr(i)) begin
            prio_d[i] = wdata[PRIO_W-1:0];
          end
        end
      end else begin
        rdata_d = read_data;
        if (addr_w == INT_CTRL_ADDR_CLAIM) begin
          for (int i = 0; i < N_SRC; i++) begin
            if (winner_valid && (winner_id == int_id_t'(i + 1))) begin
              pending_d[i]    = 1'b0;
              in_service_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // State registers; reset drops any response in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      threshold_q  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        prio_q[i] <= '0;
      end
      valid_out_q  <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      prio_q       <= prio_d;
      valid_out_q  <= valid_out_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller
// Purpose : self-checking bench for int_controller. Read responses are checked
//           against a scoreboard queue of expected data pushed when each
//           request is issued; irq and handshake signals are checked inline.
// Config  : honours INT_CTRL_EDGE_EN to check EDGE_SEL or its absence.

module tb_int_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] irq_src;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [7:0]  addr;
  logic        wena;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int          n_total;
  int          n_bad;
  logic [31:0] exp_q[$];

  int_controller #(
    .N_SRC (16),
    .PRIO_W(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .irq_src  (irq_src),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .addr     (addr),
    .wena     (wena),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    irq_src  = '0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    wena     = 1'b0;
    addr     = '0;
    wdata    = '0;
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
  endtask

  // One register access with ready_in held high. Reads push their expected
  // data and pop it when the response shows up.
  task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string name);
    int          waitc;
    logic [31:0] e;
    @(negedge clk);
    valid_in = 1'b1;
    wena     = we;
    addr     = a;
    wdata    = d;
    ready_in = 1'b1;
    if (!we) exp_q.push_back(exp);
    waitc = 0;
    while (ready_out !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    wena     = 1'b0;
    n_total++;
    if (valid_out !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s: valid_out=%b required 1", name, valid_out);
      if (!we) e = exp_q.pop_front();
    end else if (!we) begin
      e = exp_q.pop_front();
      if (rdata !== e) begin
        n_bad++;
        $display("[TB] FAIL %s: rdata=0x%08h required 0x%08h", name, rdata, e);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_total++;
    if (irq !== 1'b0 || valid_out !== 1'b0 || rdata !== 32'h0 || ready_out !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: irq=%b valid_out=%b rdata=0x%08h ready_out=%b required 0 0 0 1",
               irq, valid_out, rdata, ready_out);
    end
    do_reset();
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h0, "reset_pending");
    bus_xfer(1'b0, 8'h04, 32'h0, 32'h0, "reset_enable");
    bus_xfer(1'b0, 8'h08, 32'h0, 32'h0, "reset_threshold");
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'h0, "reset_claim");
  endtask

  task automatic test_basic_claim();
    do_reset();
    bus_xfer(1'b1, 8'h48, 32'd2, 32'h0, "wr_prio3");
    bus_xfer(1'b1, 8'h04, 32'h4, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0004;
    @(negedge clk);
    n_total++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_irq_early: irq=%b required 0", irq);
    end
    @(negedge clk);
    n_total++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL basic_irq_rise: irq=%b required 1", irq);
    end
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h4, "basic_pending");
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd3, "basic_claim");
    @(negedge clk);
    n_total++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_irq_fall: irq=%b required 0", irq);
    end
    irq_src = '0;
    bus_xfer(1'b1, 8'h0C, 32'd3, 32'h0, "basic_complete");
    tick(2);
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h0, "basic_pending_after");
  endtask

  task automatic test_tie_priority();
    do_reset();
    bus_xfer(1'b1, 8'h40, 32'd5, 32'h0, "wr_prio1");
    bus_xfer(1'b1, 8'h44, 32'd5, 32'h0, "wr_prio2");
    bus_xfer(1'b1, 8'h04, 32'h3, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0003;
    @(negedge clk);
    irq_src = '0;
    tick(2);
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h3, "tie_pending");
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd1, "tie_claim_first");
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd2, "tie_claim_second");
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd0, "tie_claim_empty");
  endtask

  task automatic test_threshold();
    do_reset();
    bus_xfer(1'b1, 8'h08, 32'd5, 32'h0, "wr_thresh5");
    bus_xfer(1'b1, 8'h4C, 32'd5, 32'h0, "wr_prio4");
    bus_xfer(1'b1, 8'h04, 32'h8, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0008;
    @(negedge clk);
    irq_src = '0;
    tick(3);
    n_total++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL thresh_equal_blocks: irq=%b required 0", irq);
    end
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd0, "thresh_claim_none");
    bus_xfer(1'b1, 8'h08, 32'd4, 32'h0, "wr_thresh4");
    @(negedge clk);
    n_total++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL thresh_lowered: irq=%b required 1", irq);
    end
    bus_xfer(1'b0, 8'h08, 32'h0, 32'd4, "thresh_readback");
  endtask

  task automatic test_complete_rearm();
    do_reset();
    bus_xfer(1'b1, 8'h48, 32'd1, 32'h0, "wr_prio3");
    bus_xfer(1'b1, 8'h04, 32'h4, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0004;
    tick(2);
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd3, "rearm_claim");
    bus_xfer(1'b1, 8'h0C, 32'h13, 32'h0, "complete_bad_id");
    bus_xfer(1'b1, 8'h0C, 32'h0, 32'h0, "complete_id0");
    tick(2);
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h0, "rearm_still_service");
    bus_xfer(1'b1, 8'h0C, 32'd3, 32'h0, "rearm_complete");
    @(negedge clk);
    n_total++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rearm_irq_gap: irq=%b required 0", irq);
    end
    @(negedge clk);
    n_total++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rearm_irq_again: irq=%b required 1", irq);
    end
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h4, "rearm_pending");
    irq_src = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    do_reset();
    bus_xfer(1'b1, 8'h48, 32'd3, 32'h0, "wr_prio3");
    bus_xfer(1'b1, 8'h40, 32'd1, 32'h0, "wr_prio1");
    bus_xfer(1'b1, 8'h04, 32'h5, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0005;
    @(negedge clk);
    irq_src = '0;
    tick(2);
    @(negedge clk);
    valid_in = 1'b1;
    wena     = 1'b0;
    addr     = 8'h0C;
    ready_in = 1'b0;
    exp_q.push_back(32'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (valid_out !== 1'b1 || rdata !== exp_q[0] || ready_out !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stall_hold: cycle=%0d valid_out=%b rdata=0x%08h ready_out=%b required 1 0x%08h 0",
                 k, valid_out, rdata, ready_out, exp_q[0]);
      end
    end
    ready_in = 1'b1;
    e = exp_q.pop_front();
    exp_q.push_back(32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (valid_out !== 1'b1 || rdata !== e) begin
      n_bad++;
      $display("[TB] FAIL stall_second_claim: valid_out=%b rdata=0x%08h required 1 0x%08h",
               valid_out, rdata, e);
    end
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h0, "stall_pending");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_xfer(1'b1, 8'h48, 32'd2, 32'h0, "wr_prio3");
    bus_xfer(1'b1, 8'h04, 32'h4, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0004;
    @(negedge clk);
    irq_src = '0;
    tick(2);
    @(negedge clk);
    valid_in = 1'b1;
    addr     = 8'h0C;
    ready_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    reset_n  = 1'b0;
    #1;
    n_total++;
    if (valid_out !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid: valid_out=%b rdata=0x%08h irq=%b required 0 0 0",
               valid_out, rdata, irq);
    end
    do_reset();
    bus_xfer(1'b0, 8'h04, 32'h0, 32'h0, "reset_mid_enable");
  endtask

  task automatic test_register_map();
    do_reset();
    bus_xfer(1'b1, 8'h04, 32'hFFFFFFFF, 32'h0, "wr_enable_all");
    bus_xfer(1'b0, 8'h04, 32'h0, 32'h0000FFFF, "enable_width");
    bus_xfer(1'b0, 8'h05, 32'h0, 32'h0000FFFF, "addr_low_bits");
    bus_xfer(1'b1, 8'h7C, 32'hFFFFFFFF, 32'h0, "wr_prio16");
    bus_xfer(1'b0, 8'h7C, 32'h0, 32'h7, "prio16_width");
    bus_xfer(1'b1, 8'h00, 32'hFFFF, 32'h0, "wr_pending");
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h0, "pending_ro");
    bus_xfer(1'b0, 8'h20, 32'h0, 32'h0, "unmapped_20");
    bus_xfer(1'b1, 8'h80, 32'h7, 32'h0, "wr_beyond_prio");
    bus_xfer(1'b0, 8'h80, 32'h0, 32'h0, "unmapped_80");
  endtask

  task automatic test_edge_config();
    do_reset();
`ifdef INT_CTRL_EDGE_EN
    bus_xfer(1'b1, 8'h10, 32'h1, 32'h0, "wr_edge_sel");
    bus_xfer(1'b0, 8'h10, 32'h0, 32'h1, "edge_sel_readback");
    bus_xfer(1'b1, 8'h40, 32'd1, 32'h0, "wr_prio1");
    bus_xfer(1'b1, 8'h04, 32'h1, 32'h0, "wr_enable");
    @(negedge clk);
    irq_src = 16'h0001;
    @(negedge clk);
    irq_src = '0;
    tick(2);
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h1, "edge_pulse_pending");
    bus_xfer(1'b0, 8'h0C, 32'h0, 32'd1, "edge_claim");
    irq_src = 16'h0001;
    tick(2);
    bus_xfer(1'b1, 8'h0C, 32'd1, 32'h0, "edge_complete");
    tick(3);
    bus_xfer(1'b0, 8'h00, 32'h0, 32'h0, "edge_held_no_repend");
    irq_src = '0;
`else
    bus_xfer(1'b1, 8'h10, 32'h1, 32'h0, "wr_edge_sel");
    bus_xfer(1'b0, 8'h10, 32'h0, 32'h0, "edge_sel_unmapped");
`endif
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    irq_src  = '0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    wena     = 1'b0;
    addr     = '0;
    wdata    = '0;
    tick(2);
    reset_n = 1'b1;
    test_reset();
    test_basic_claim();
    test_tie_priority();
    test_threshold();
    test_complete_rearm();
    test_back_to_back();
    test_reset_mid();
    test_register_map();
    test_edge_config();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
